// File: rtl/imem_resp.sv
// Instruction-fetch memory slave: accepts one read at a time, waits LATENCY cycles,
// then presents a registered word (or SLVERR) until the consumer takes it.
module imem_resp #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  arvalid_i,
  input  logic [31:0]           araddr_i,
  output logic                  arready_o,
  output logic [31:0]           rdata_o,
  output logic                  rvalid_o,
  output logic [1:0]            rresp_o,
  input  logic                  rready_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           resp_cnt_o
);

  localparam int unsigned Depth      = 1 << DEPTH_LOG2;
  localparam logic [32:0] LimitBytes = 33'd4 << DEPTH_LOG2;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rvalid_q;
  logic [31:0] resp_cnt_q;

  logic [31:0] mem_q [Depth];

  logic                  in_idle;
  logic [31:0]           lookup_addr;
  logic [31:0]           offset;
  logic                  addr_err;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           lookup_data;
  logic [1:0]            lookup_resp;

  assign in_idle = (state_q == StIdle);

  // With zero latency the response is loaded on the accept edge, so use the live address.
  assign lookup_addr = in_idle ? araddr_i : addr_q;
  assign offset      = lookup_addr - ADDR_BASE;
  assign addr_err    = (lookup_addr[1:0] != 2'b00) || ({1'b0, offset} >= LimitBytes);
  assign word_idx    = DEPTH_LOG2'(offset >> 2);
  assign lookup_data = addr_err ? 32'h0 : mem_q[word_idx];
  assign lookup_resp = addr_err ? RespSlvErr : RespOkay;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      addr_q     <= 32'h0;
      rdata_q    <= 32'h0;
      rresp_q    <= RespOkay;
      rvalid_q   <= 1'b0;
      resp_cnt_q <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arvalid_i) begin
            addr_q <= araddr_i;
            if (LATENCY == 0) begin
              state_q  <= StResp;
              rvalid_q <= 1'b1;
              rdata_q  <= lookup_data;
              rresp_q  <= lookup_resp;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(LATENCY);
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= StResp;
            rvalid_q <= 1'b1;
            rdata_q  <= lookup_data;
            rresp_q  <= lookup_resp;
          end
        end
        StResp: begin
          if (rready_i) begin
            state_q    <= StIdle;
            rvalid_q   <= 1'b0;
            resp_cnt_q <= resp_cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Contents survive reset; a write on the RESP-entry edge lands after the read above.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign arready_o  = in_idle;
  assign rdata_o    = rdata_q;
  assign rresp_o    = rresp_q;
  assign rvalid_o   = rvalid_q;
  assign resp_cnt_o = resp_cnt_q;

endmodule
